// File: rtl/multicycle_control_if.sv
// Control/datapath bundle for the multi-cycle MIPS controller.
// master = controller side, slave = datapath side.
interface multicycle_control_if #(
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      Instr;
  logic             Zero;
  logic             Mem_Ack;
  logic             IR_LdEn;
  logic             PC_sel;
  logic             PC_LdEn;
  logic             RF_B_sel;
  logic [1:0]       Imm_mode;
  logic             ALU_Bin_sel;
  logic [3:0]       ALU_func;
  logic             Mem_Req;
  logic             Mem_WrEn;
  logic             RF_WrEn;
  logic             RF_WrData_sel;
  logic             Err;
  logic [CNT_W-1:0] Retired;

  modport master (
    input  Instr, Zero, Mem_Ack,
    output IR_LdEn, PC_sel, PC_LdEn, RF_B_sel, Imm_mode, ALU_Bin_sel,
           ALU_func, Mem_Req, Mem_WrEn, RF_WrEn, RF_WrData_sel, Err, Retired
  );

  modport slave (
    output Instr, Zero, Mem_Ack,
    input  IR_LdEn, PC_sel, PC_LdEn, RF_B_sel, Imm_mode, ALU_Bin_sel,
           ALU_func, Mem_Req, Mem_WrEn, RF_WrEn, RF_WrData_sel, Err, Retired
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: fetch, decode, ALU, memory and write-back
// sequencing with a timed-out memory handshake and a retired-instruction count.
// Control strobes are decoded from the state register (PC_sel/PC_LdEn also
// look at Zero/Mem_Ack) and are forced low while Reset is asserted.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  multicycle_control_if.master bus
);

  localparam int unsigned TMO_W = 8;
  localparam int unsigned OP_W  = 6;
  localparam int unsigned FN_W  = 4;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b100000;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b110000;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b110010;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b110011;
  localparam logic [OP_W-1:0] OP_LW    = 6'b001111;
  localparam logic [OP_W-1:0] OP_SW    = 6'b011111;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000000;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000001;
  localparam logic [OP_W-1:0] OP_B     = 6'b111111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  localparam logic [1:0] IMM_SEXT    = 2'b00;
  localparam logic [1:0] IMM_ZEXT    = 2'b01;
  localparam logic [1:0] IMM_SEXT_S2 = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_ALU,
    S_MEM,
    S_WB,
    S_BRANCH,
    S_HALT
  } state_t;

  state_t           state_q, next_state;
  logic [OP_W-1:0]  op_q;
  logic [FN_W-1:0]  fn_q;
  logic [TMO_W-1:0] tmo_q, tmo_d, tmo_inc;
  logic             err_q, err_set;
  logic [CNT_W-1:0] retired_q;

  logic is_r, is_addi, is_andi, is_ori, is_lw, is_sw, is_beq, is_bne, is_b;
  logic is_branch, is_legal, is_imm_alu;
  logic [3:0] alu_op;
  logic [1:0] imm_op;

  logic       ir_ld_c, pc_sel_c, pc_ld_c, rf_b_sel_c, alu_bin_c;
  logic       mem_req_c, mem_wr_c, rf_we_c, rf_wd_sel_c;
  logic [1:0] imm_mode_c;
  logic [3:0] alu_func_c;

  // Instruction bits the controller never looks at.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{bus.Instr[25:4]};

  // Opcode classification from the latched instruction fields.
  always_comb begin
    is_r       = (op_q == OP_RTYPE);
    is_addi    = (op_q == OP_ADDI);
    is_andi    = (op_q == OP_ANDI);
    is_ori     = (op_q == OP_ORI);
    is_lw      = (op_q == OP_LW);
    is_sw      = (op_q == OP_SW);
    is_beq     = (op_q == OP_BEQ);
    is_bne     = (op_q == OP_BNE);
    is_b       = (op_q == OP_B);
    is_branch  = is_beq | is_bne | is_b;
    is_imm_alu = is_addi | is_andi | is_ori | is_lw | is_sw;
    is_legal   = is_r | is_imm_alu | is_branch;
    if (is_r)                 alu_op = fn_q;
    else if (is_andi)         alu_op = ALU_AND;
    else if (is_ori)          alu_op = ALU_OR;
    else                      alu_op = ALU_ADD;
    if (is_andi | is_ori)     imm_op = IMM_ZEXT;
    else if (is_branch)       imm_op = IMM_SEXT_S2;
    else                      imm_op = IMM_SEXT;
  end

  assign tmo_inc = tmo_q + TMO_W'(1);

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= S_FETCH;
    else        state_q <= next_state;
  end

  // Next-state and control decode.
  always_comb begin
    next_state  = state_q;
    tmo_d       = '0;
    err_set     = 1'b0;
    ir_ld_c     = 1'b0;
    pc_sel_c    = 1'b0;
    pc_ld_c     = 1'b0;
    rf_b_sel_c  = 1'b0;
    imm_mode_c  = IMM_SEXT;
    alu_bin_c   = 1'b0;
    alu_func_c  = ALU_ADD;
    mem_req_c   = 1'b0;
    mem_wr_c    = 1'b0;
    rf_we_c     = 1'b0;
    rf_wd_sel_c = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ir_ld_c    = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        rf_b_sel_c = is_sw | is_beq | is_bne;
        imm_mode_c = imm_op;
        if (!is_legal) begin
          next_state = S_HALT;
          err_set    = 1'b1;
        end else if (is_branch) begin
          next_state = S_BRANCH;
        end else begin
          next_state = S_ALU;
        end
      end
      S_ALU: begin
        rf_b_sel_c = is_sw;
        imm_mode_c = imm_op;
        alu_bin_c  = is_imm_alu;
        alu_func_c = alu_op;
        next_state = (is_lw | is_sw) ? S_MEM : S_WB;
      end
      S_MEM: begin
        rf_b_sel_c = is_sw;
        imm_mode_c = imm_op;
        alu_bin_c  = is_imm_alu;
        alu_func_c = alu_op;
        mem_req_c  = 1'b1;
        mem_wr_c   = is_sw;
        if (bus.Mem_Ack) begin
          if (is_lw) begin
            next_state = S_WB;
          end else begin
            pc_ld_c    = 1'b1;
            next_state = S_FETCH;
          end
        end else if (tmo_inc == TMO_W'(MEM_TIMEOUT)) begin
          next_state = S_HALT;
          err_set    = 1'b1;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      S_WB: begin
        rf_we_c     = 1'b1;
        rf_wd_sel_c = is_lw;
        pc_ld_c     = 1'b1;
        next_state  = S_FETCH;
      end
      S_BRANCH: begin
        alu_func_c = ALU_SUB;
        imm_mode_c = IMM_SEXT_S2;
        pc_ld_c    = 1'b1;
        pc_sel_c   = is_b | (is_beq & bus.Zero) | (is_bne & ~bus.Zero);
        next_state = S_FETCH;
      end
      S_HALT: begin
        next_state = S_HALT;
      end
      default: begin
        next_state = S_HALT;
      end
    endcase
  end

  // Instruction-register fields captured at the end of fetch.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      op_q <= '0;
      fn_q <= '0;
    end else if (ir_ld_c) begin
      op_q <= bus.Instr[31:26];
      fn_q <= bus.Instr[3:0];
    end
  end

  // Memory wait counter, sticky error and retired-instruction count.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      tmo_q     <= '0;
      err_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_q | err_set;
      if (pc_ld_c) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign bus.IR_LdEn       = Reset & ir_ld_c;
  assign bus.PC_sel        = Reset & pc_sel_c;
  assign bus.PC_LdEn       = Reset & pc_ld_c;
  assign bus.RF_B_sel      = Reset & rf_b_sel_c;
  assign bus.Imm_mode      = Reset ? imm_mode_c : 2'b00;
  assign bus.ALU_Bin_sel   = Reset & alu_bin_c;
  assign bus.ALU_func      = Reset ? alu_func_c : 4'b0000;
  assign bus.Mem_Req       = Reset & mem_req_c;
  assign bus.Mem_WrEn      = Reset & mem_wr_c;
  assign bus.RF_WrEn       = Reset & rf_we_c;
  assign bus.RF_WrData_sel = Reset & rf_wd_sel_c;
  assign bus.Err           = err_q;
  assign bus.Retired       = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each issued instruction pushes its
// expected retirement record; a monitor pops and compares on every PC_LdEn.
module tb_multicycle_control;

  localparam int unsigned CNT_W_TB = 3;
  localparam int unsigned TMO_TB   = 4;

  typedef struct {
    string                nm;
    logic                 pc_sel;
    logic                 rf_we;
    logic                 wd_sel;
    int                   lat;
    int                   memc;
    logic                 memwr;
    logic [3:0]           alu3;
    logic                 bin3;
    logic [CNT_W_TB-1:0]  ret;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  logic [CNT_W_TB-1:0] exp_ret = '0;

  multicycle_control_if #(.CNT_W(CNT_W_TB)) bus ();

  multicycle_control #(
    .MEM_TIMEOUT(TMO_TB),
    .CNT_W      (CNT_W_TB)
  ) u_dut (
    .Clk  (clk),
    .Reset(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: per-instruction bookkeeping and scoreboard pop on each retirement.
  initial begin : monitor
    int         cyc;
    int         memc;
    logic       memwr_any;
    logic [3:0] alu3;
    logic       bin3;
    exp_t       e;
    cyc = 0; memc = 0; memwr_any = 1'b0; alu3 = '0; bin3 = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.IR_LdEn) begin
        cyc = 1; memc = 0; memwr_any = 1'b0;
      end else begin
        cyc++;
      end
      if (cyc == 3) begin
        alu3 = bus.ALU_func;
        bin3 = bus.ALU_Bin_sel;
      end
      if (bus.Mem_Req) begin
        memc++;
        if (bus.Mem_WrEn) memwr_any = 1'b1;
      end
      if (bus.RF_WrEn && bus.Mem_Req) begin
        errors++;
        $display("FAIL rf_we_with_mem_req: got 1 expected 0");
      end
      if (bus.PC_LdEn) begin
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_retire: got PC_LdEn=1 expected 0");
        end else begin
          e = sbq.pop_front();
          chk({e.nm, "_pc_sel"},  32'(bus.PC_sel),        32'(e.pc_sel));
          chk({e.nm, "_rf_we"},   32'(bus.RF_WrEn),       32'(e.rf_we));
          chk({e.nm, "_wd_sel"},  32'(bus.RF_WrData_sel), 32'(e.wd_sel));
          chk({e.nm, "_latency"}, 32'(cyc),               32'(e.lat));
          chk({e.nm, "_memc"},    32'(memc),              32'(e.memc));
          chk({e.nm, "_memwr"},   32'(memwr_any),         32'(e.memwr));
          chk({e.nm, "_alu3"},    32'(alu3),              32'(e.alu3));
          chk({e.nm, "_bin3"},    32'(bin3),              32'(e.bin3));
          chk({e.nm, "_retired"}, 32'(bus.Retired),       32'(e.ret));
        end
      end
    end
  end

  // Issue one instruction starting in its fetch cycle; acks the memory on the
  // (ack_n+1)-th request cycle (ack_n < 0 means never) and runs lat cycles.
  task automatic run_instr(input string nm, input logic [31:0] ins, input logic z,
                           input int ack_n, input int lat, input logic psel,
                           input logic rfwe, input logic wd, input int memc,
                           input logic memwr, input logic [3:0] alu3, input logic bin3);
    exp_t e;
    int   mc;
    e.nm = nm; e.pc_sel = psel; e.rf_we = rfwe; e.wd_sel = wd; e.lat = lat;
    e.memc = memc; e.memwr = memwr; e.alu3 = alu3; e.bin3 = bin3; e.ret = exp_ret;
    sbq.push_back(e);
    exp_ret = exp_ret + CNT_W_TB'(1);
    bus.Instr = ins;
    bus.Zero  = z;
    mc = 0;
    for (int k = 0; k < lat; k++) begin
      bus.Mem_Ack = bus.Mem_Req && (mc == ack_n);
      if (bus.Mem_Req) mc++;
      @(posedge clk); #1;
    end
    bus.Mem_Ack = 1'b0;
  endtask

  initial begin : stim
    int memc, memwr, irc, bad;
    logic err_dec, err_after;
    rst_n = 1'b0;
    bus.Instr = '0; bus.Zero = 1'b0; bus.Mem_Ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ir_ld",   32'(bus.IR_LdEn), 0);
    chk("rst_pc_ld",   32'(bus.PC_LdEn), 0);
    chk("rst_mem_req", 32'(bus.Mem_Req), 0);
    chk("rst_err",     32'(bus.Err),     0);
    chk("rst_retired", 32'(bus.Retired), 0);
    rst_n = 1'b1;
    #1;
    chk("first_fetch_ir_ld", 32'(bus.IR_LdEn), 1);

    //          name     instr          Z  ack lat psel rfwe wd memc mw  alu3  bin
    run_instr("rtype",  32'h8022_1830, 0, -1, 4,  0,   1,  0, 0,   0, 4'h0, 0);
    run_instr("lw_n2",  32'h3C22_0004, 0,  2, 7,  0,   1,  1, 3,   0, 4'h0, 1);
    run_instr("addi",   32'hC022_0005, 0, -1, 4,  0,   1,  0, 0,   0, 4'h0, 1);
    run_instr("andi",   32'hC822_0005, 0, -1, 4,  0,   1,  0, 0,   0, 4'h2, 1);
    run_instr("ori",    32'hCC22_0005, 0, -1, 4,  0,   1,  0, 0,   0, 4'h3, 1);
    run_instr("rsub",   32'h8022_1801, 0, -1, 4,  0,   1,  0, 0,   0, 4'h1, 0);
    run_instr("beq_z1", 32'h0022_0003, 1, -1, 3,  1,   0,  0, 0,   0, 4'h1, 0);
    run_instr("beq_z0", 32'h0022_0003, 0, -1, 3,  0,   0,  0, 0,   0, 4'h1, 0);
    run_instr("bne_z1", 32'h0422_0003, 1, -1, 3,  0,   0,  0, 0,   0, 4'h1, 0);
    run_instr("bne_z0", 32'h0422_0003, 0, -1, 3,  1,   0,  0, 0,   0, 4'h1, 0);
    run_instr("b_z0",   32'hFC00_0003, 0, -1, 3,  1,   0,  0, 0,   0, 4'h1, 0);
    run_instr("b_z1",   32'hFC00_0003, 1, -1, 3,  1,   0,  0, 0,   0, 4'h1, 0);
    run_instr("sw_n0",  32'h7C22_0000, 0,  0, 4,  0,   0,  0, 1,   1, 4'h0, 1);
    run_instr("sw_n3",  32'h7C22_0000, 0,  3, 7,  0,   0,  0, 4,   1, 4'h0, 1);
    run_instr("lw_n0",  32'h3C22_0000, 0,  0, 5,  0,   1,  1, 1,   0, 4'h0, 1);

    // sw with no ack: times out after TMO_TB request cycles and halts.
    bus.Instr = 32'h7C22_0000;
    memc = 0; memwr = 0; irc = 0; bad = 0;
    for (int k = 0; k < 30; k++) begin
      if (bus.Mem_Req)  memc++;
      if (bus.Mem_WrEn) memwr++;
      if (bus.IR_LdEn)  irc++;
      if (k >= 7 && (bus.PC_LdEn || bus.RF_WrEn || bus.Mem_Req || bus.IR_LdEn)) bad++;
      @(posedge clk); #1;
    end
    chk("tmo_mem_req_cycles", 32'(memc), TMO_TB);
    chk("tmo_mem_wr_cycles",  32'(memwr), TMO_TB);
    chk("tmo_single_fetch",   32'(irc), 1);
    chk("halt_quiet",         32'(bad), 0);
    chk("halt_err",           32'(bus.Err), 1);
    chk("halt_retired",       32'(bus.Retired), 32'(exp_ret));

    rst_n = 1'b0;
    #1;
    chk("rst2_err",     32'(bus.Err), 0);
    chk("rst2_retired", 32'(bus.Retired), 0);
    exp_ret = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Illegal opcode: error on leaving decode, no side effects.
    bus.Instr = 32'h5400_0000;
    bad = 0; err_dec = 1'b0; err_after = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k == 1) err_dec = bus.Err;
      if (k == 2) err_after = bus.Err;
      if (bus.PC_LdEn || bus.RF_WrEn || bus.Mem_Req) bad++;
      @(posedge clk); #1;
    end
    chk("illegal_err_in_decode", 32'(err_dec), 0);
    chk("illegal_err_after",     32'(err_after), 1);
    chk("illegal_no_effects",    32'(bad), 0);
    rst_n = 1'b0;
    #1;
    chk("rst3_err",     32'(bus.Err), 0);
    chk("rst3_retired", 32'(bus.Retired), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;

    // Reset during the second memory cycle of lw.
    bus.Instr = 32'h3C22_0004;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("lw_mem2_req", 32'(bus.Mem_Req), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_mem_req_drop", 32'(bus.Mem_Req), 0);
    chk("async_no_rf_we",     32'(bus.RF_WrEn), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_ir_ld",   32'(bus.IR_LdEn), 1);
    chk("post_rst_retired", 32'(bus.Retired), 0);
    run_instr("rtype_after_rst", 32'h8022_1830, 0, -1, 4, 0, 1, 0, 0, 0, 4'h0, 0);

    @(posedge clk); #1;
    chk("sb_drain", 32'(sbq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle control FSM for the MIPS datapath.
- Sequences the instruction-fetch stage (drives PC_sel/PC_LdEn), decode, ALU, data-memory and register-file write-back enables.
- Executes one instruction per 3–5+ cycles.
- Fetch stage supplies Instr; ALU supplies Zero; data memory uses a req/ack handshake with timeout.

Parameters:
- MEM_TIMEOUT, 15, max cycles in S_MEM waiting for Mem_Ack before error halt (legal range 1..255).
- CNT_W, 16, width of retired-instruction counter.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Instr  in  32  current instruction from fetch stage.
- Zero  in  1  ALU zero flag, combinational, valid in the same cycle as ALU_func.
- Mem_Ack  in  1  data-memory completion, 1-cycle pulse.
- IR_LdEn  out  1  latch Instr into instruction register.
- PC_sel  out  1  0 = PC+4, 1 = PC+4+Immed.
- PC_LdEn  out  1  PC update strobe.
- RF_B_sel  out  1  0 = read Instr[15:11], 1 = Instr[20:16].
- Imm_mode  out  2  00 sign-ext, 01 zero-ext, 10 sign-ext<<2.
- ALU_Bin_sel  out  1  0 = register B, 1 = immediate.
- ALU_func  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, else from funct.
- Mem_Req  out  1  data-memory request, held until ack.
- Mem_WrEn  out  1  write qualifier, valid with Mem_Req.
- RF_WrEn  out  1  register-file write strobe.
- RF_WrData_sel  out  1  0 = ALU result, 1 = memory data.
- Err  out  1  sticky fault flag.
- Retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset low (async): state = S_FETCH; all outputs 0; Err = 0; Retired = 0; timeout counter = 0. Takes effect immediately, including mid-S_MEM (Mem_Req drops in the same instant). First S_FETCH cycle follows reset release.
- Opcode = latched Instr[31:26]. Only these are legal; all others are illegal:
  - 100000 R-type: ALU_func = Instr[3:0].
  - 110000 addi: ADD, sign-ext.
  - 110010 andi: AND, zero-ext.
  - 110011 ori: OR, zero-ext.
  - 001111 lw.
  - 011111 sw.
  - 000000 beq.
  - 000001 bne.
  - 111111 b.
- S_FETCH: IR_LdEn = 1 for one cycle; latch opcode and funct. Next state S_DECODE.
- S_DECODE: RF_B_sel = 1 for sw/beq/bne, else 0; Imm_mode per opcode.
  - Legal, non-branch → S_ALU.
  - Branch → S_BRANCH.
  - Illegal → S_HALT with Err = 1.
- S_ALU: ALU_Bin_sel = 1 for I-type/lw/sw; ALU_func per opcode (ADD for lw/sw). Next state S_MEM for lw/sw, else S_WB.
- S_MEM:
  - Mem_Req = 1; Mem_WrEn = 1 iff sw; ALU controls held.
  - Timeout counter increments each cycle without Mem_Ack.
  - Mem_Ack in the same cycle counter would reach MEM_TIMEOUT counts as success.
  - Mem_Ack, lw → S_WB.
  - Mem_Ack, sw → PC_LdEn = 1, PC_sel = 0, Retired++ in that cycle, then S_FETCH.
  - Counter reaches MEM_TIMEOUT with no ack → S_HALT, Err = 1.
  - Counter clears on leaving S_MEM.
- S_WB:
  - RF_WrEn = 1; RF_WrData_sel = 1 iff lw.
  - PC_LdEn = 1, PC_sel = 0; Retired++.
  - Next state S_FETCH.
- S_BRANCH:
  - ALU_func = SUB, ALU_Bin_sel = 0, Imm_mode = 10.
  - PC_LdEn = 1; Retired++; next state S_FETCH.
  - PC_sel (Mealy on Zero) = b | (beq & Zero) | (bne & ~Zero).
- S_HALT: all enables 0, Err = 1, Retired frozen. Exit only via reset.
- Invariants:
  - PC_LdEn is high for exactly one cycle per retired instruction, never in S_FETCH/S_DECODE/S_ALU.
  - RF_WrEn and Mem_Req are never high together.
  - Retired wraps 2^CNT_W−1 → 0.
- Latency (cycles from S_FETCH entry to PC update cycle, inclusive):
  - R/I ALU ops: 4.
  - Branches: 3.
  - sw: 4 + N.
  - lw: 5 + N.
  - N = Mem_Ack wait cycles (ack in first S_MEM cycle is N = 0).

Test Plan:
- Reset, Instr = 0x8022_1830 (R-type, funct 0x30) → S_FETCH, S_DECODE, S_ALU, S_WB. ALU_func = 0000 in cycle 3; RF_WrEn = PC_LdEn = 1 only in cycle 4, PC_sel = 0; Retired = 1.
- lw (0x3C..), Mem_Ack in 3rd S_MEM cycle → Mem_Req high 3 cycles with Mem_WrEn = 0. S_WB has RF_WrData_sel = 1; total 7 cycles; Retired += 1.
- beq with Zero = 1 → PC_sel = 1, PC_LdEn = 1 in cycle 3. beq with Zero = 0 → PC_sel = 0. bne inverts. b gives PC_sel = 1 regardless of Zero.
- sw, MEM_TIMEOUT = 4, Mem_Ack never → Mem_Req/Mem_WrEn high 4 cycles, then S_HALT with Err = 1. All enables 0 and PC_LdEn stays 0 for 20+ cycles.
- Illegal opcode 010101 → Err = 1 at S_DECODE exit; no PC_LdEn, RF_WrEn or Mem_Req ever. Reset clears Err = 0 and Retired = 0.
- Reset low in 2nd S_MEM cycle of lw → Mem_Req drops without a clock edge; no RF_WrEn. After release, IR_LdEn = 1 on the first cycle and Retired = 0.
